// File: rtl/spi_flash_pkg.sv
// Shared constants, FSM state type and parameter checks for the burst SPI flash controller.
package spi_flash_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam int         SPI_ADDR_BITS = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSGAP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_STREAM
    } spi_state_e;

    function automatic bit data_bytes_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4);
    endfunction

endpackage

// File: rtl/spi_flash_burst_controller_if.sv
// Instruction-fetch bus between the address decoder / core and the flash controller.
interface spi_flash_burst_controller_if #(
    parameter int ADDR_W     = 24,
    parameter int DATA_BYTES = 1
);
    logic                    chipSel;
    logic                    readMem;
    logic [ADDR_W-1:0]       addressBus;
    logic [8*DATA_BYTES-1:0] dataOut;
    logic                    ready;

    modport master (output chipSel, readMem, addressBus, input dataOut, ready);
    modport slave  (input chipSel, readMem, addressBus, output dataOut, ready);
endinterface

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI bit engine: divides SCK from clk, shifts nbits MSB first and samples DO
// on each SCK rising edge. A start on the done cycle chains the next burst gaplessly.
module spi_shift_engine #(
    parameter int SCK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [5:0]  nbits_i,
    input  logic [31:0] tx_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rx_data_o,
    output logic        sck_o,
    output logic        di_o,
    input  logic        do_i
);
    localparam int               DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [5:0]       bit_cnt_q;
    logic             busy_q;
    logic             sck_q;
    logic [31:0]      tx_q;
    logic [31:0]      rx_q;
    logic             tick;

    assign tick      = busy_q && (div_cnt_q == DIV_LAST);
    assign done_o    = tick && sck_q && (bit_cnt_q == 6'd1);
    assign busy_o    = busy_q;
    assign rx_data_o = rx_q;
    assign sck_o     = sck_q;
    assign di_o      = busy_q & tx_q[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            sck_q     <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= nbits_i;
            tx_q      <= tx_data_i;
        end else if (busy_q) begin
            if (tick) begin
                div_cnt_q <= '0;
                sck_q     <= ~sck_q;
                if (!sck_q) begin
                    rx_q <= {rx_q[30:0], do_i};
                end else begin
                    // DI only moves here, on the falling edge
                    tx_q      <= {tx_q[30:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q - 6'd1;
                    if (bit_cnt_q == 6'd1) begin
                        busy_q <= 1'b0;
                    end
                end
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_flash_burst_controller.sv
// SPI NOR READ (0x03) fetch controller returning DATA_BYTES little-endian bytes per access,
// keeping the frame open so sequential fetches skip command and address.
module spi_flash_burst_controller
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int DATA_BYTES   = 1,
    parameter int SCK_DIV      = 1,
    parameter int CS_HIGH_MIN  = 2,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    spi_flash_burst_controller_if.slave bus,
    output logic SCK,
    output logic CSbar,
    output logic DI,
    input  logic DO
);
    localparam int DATA_BITS = 8 * DATA_BYTES;
    localparam int GAP_W     = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;
    localparam int IDLE_W    = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    if (!data_bytes_legal(DATA_BYTES) || ADDR_W != SPI_ADDR_BITS || SCK_DIV < 1 || CS_HIGH_MIN < 1) begin : g_bad_params
        $error("spi_flash_burst_controller: illegal parameter set");
    end

    spi_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                  cs_q, cs_d;
    logic                  ready_q, ready_d;
    logic [DATA_BITS-1:0]  data_q, data_d;

    logic                  eng_start, eng_busy, eng_done;
    logic [5:0]            eng_nbits;
    logic [31:0]           eng_tx, eng_rx;
    logic [DATA_BITS-1:0]  rx_packed;
    logic                  unused_rx;
    logic                  req;
    logic [ADDR_W-1:0]     next_addr;

    assign req       = bus.chipSel & bus.readMem;
    assign next_addr = addr_q + ADDR_W'(DATA_BYTES);
    assign unused_rx = ^eng_rx;

    // First byte on the wire is the lowest address, so it lands in the top received byte
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_pack
        assign rx_packed[8*gi +: 8] = eng_rx[8*(DATA_BYTES-1-gi) +: 8];
    end

    spi_shift_engine #(.SCK_DIV(SCK_DIV)) u_engine (
        .clk       (clk),
        .rst_n     (rst),
        .start_i   (eng_start),
        .nbits_i   (eng_nbits),
        .tx_data_i (eng_tx),
        .busy_o    (eng_busy),
        .done_o    (eng_done),
        .rx_data_o (eng_rx),
        .sck_o     (SCK),
        .di_o      (DI),
        .do_i      (DO)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            gap_cnt_q  <= '0;
            idle_cnt_q <= '0;
            cs_q       <= 1'b1;
            ready_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            gap_cnt_q  <= gap_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            cs_q       <= cs_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        gap_cnt_d  = gap_cnt_q;
        idle_cnt_d = idle_cnt_q;
        cs_d       = cs_q;
        ready_d    = 1'b0;
        data_d     = data_q;
        eng_start  = 1'b0;
        eng_nbits  = 6'd0;
        eng_tx     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_CMD;
                    cs_d    = 1'b0;
                    addr_d  = bus.addressBus;
                end
            end
            ST_CSGAP: begin
                if (gap_cnt_q == '0) begin
                    if (req) begin
                        state_d = ST_CMD;
                        cs_d    = 1'b0;
                        addr_d  = bus.addressBus;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_CMD: begin
                if (!eng_busy) begin
                    eng_start = 1'b1;
                    eng_nbits = 6'd8;
                    eng_tx    = {SPI_CMD_READ, 24'h000000};
                end else if (eng_done) begin
                    state_d   = ST_ADDR;
                    eng_start = 1'b1;
                    eng_nbits = 6'd24;
                    eng_tx    = {addr_q, 8'h00};
                end
            end
            ST_ADDR: begin
                if (eng_done) begin
                    state_d   = ST_DATA;
                    eng_start = 1'b1;
                    eng_nbits = 6'(DATA_BITS);
                end
            end
            ST_DATA: begin
                if (eng_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // An abandoned request still finishes the burst but is not reported
                if (req) begin
                    ready_d = 1'b1;
                    data_d  = rx_packed;
                end
                if (HOLD_TIMEOUT > 0) begin
                    state_d    = ST_STREAM;
                    idle_cnt_d = '0;
                end else begin
                    state_d   = ST_CSGAP;
                    cs_d      = 1'b1;
                    gap_cnt_d = GAP_W'(CS_HIGH_MIN - 1);
                end
            end
            ST_STREAM: begin
                if (req && bus.addressBus == next_addr) begin
                    state_d   = ST_DATA;
                    addr_d    = bus.addressBus;
                    eng_start = 1'b1;
                    eng_nbits = 6'(DATA_BITS);
                end else if (req || idle_cnt_q == IDLE_W'(HOLD_TIMEOUT - 1)) begin
                    state_d   = ST_CSGAP;
                    cs_d      = 1'b1;
                    gap_cnt_d = GAP_W'(CS_HIGH_MIN - 1);
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign CSbar       = cs_q;
    assign bus.ready   = ready_q;
    assign bus.dataOut = data_q;

endmodule

// File: tb/tb_spi_flash_burst_controller.sv
// Randomised fetch sequences against an SPI NOR flash model and a latency/data reference model.
module tb_spi_flash_burst_controller;

    localparam int N        = 4;
    localparam int D        = 1;
    localparam int C        = 2;
    localparam int H        = 64;
    localparam int COLD_LAT = 2 + 2*D*(32 + 8*N);
    localparam int STRM_LAT = 2*D*8*N + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic SCK, CSbar, DI;
    logic DO = 1'b0;

    always #5 clk = ~clk;

    spi_flash_burst_controller_if #(.ADDR_W(24), .DATA_BYTES(N)) bus ();

    spi_flash_burst_controller #(
        .ADDR_W(24), .DATA_BYTES(N), .SCK_DIV(D), .CS_HIGH_MIN(C), .HOLD_TIMEOUT(H)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .SCK   (SCK),
        .CSbar (CSbar),
        .DI    (DI),
        .DO    (DO)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash contents: a few fixed bytes, the rest a simple address hash
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA5;
            24'h000020: return 8'h11;
            24'h000021: return 8'h22;
            24'h000022: return 8'h33;
            24'h000023: return 8'h44;
            default:    return a[7:0] ^ (a[15:8] * 8'd3) ^ (a[23:16] * 8'd7) ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [8*N-1:0] exp_word(input logic [23:0] a);
        logic [8*N-1:0] w;
        for (int i = 0; i < N; i++) w[8*i +: 8] = flash_byte(a + 24'(i));
        return w;
    endfunction

    // SPI NOR slave: header on rising SCK, data driven after each falling SCK
    int unsigned  fbits  = 0;
    int           frames = 0;
    logic [31:0]  fhdr   = '0;
    logic [7:0]   f_cmd  = '0;
    logic [23:0]  f_addr = '0;

    always @(negedge CSbar or posedge SCK) begin
        if (SCK) begin
            if (fbits < 32) fhdr = {fhdr[30:0], DI};
            fbits++;
            if (fbits == 32) begin
                f_cmd  = fhdr[31:24];
                f_addr = fhdr[23:0];
            end
        end else begin
            fbits = 0;
            frames++;
        end
    end

    always @(negedge SCK) begin
        int unsigned k;
        logic [7:0]  b;
        if (!CSbar && fbits >= 32) begin
            k  = fbits - 32;
            b  = flash_byte(f_addr + 24'(k / 8));
            DO = b[7 - (k % 8)];
        end
    end

    bit bad_sck = 0;
    bit bad_di  = 0;
    always @(negedge clk) if (SCK === 1'b1 && CSbar === 1'b1) bad_sck = 1;
    always @(DI) if (rst === 1'b1 && SCK === 1'b1) bad_di = 1;

    // Reference model state: is a frame held open, and the last address served
    bit          open = 0;
    logic [23:0] last = '0;

    task automatic do_read(input logic [23:0] a, input int exp_lat, input int exp_csh,
                           input int exp_frame, input string kind);
        int n = 0, csh = 0, f0;
        bit got = 0;
        f0 = frames;
        bus.chipSel = 1'b1; bus.readMem = 1'b1; bus.addressBus = a;
        while (n < 400 && !got) begin
            @(posedge clk); #1;
            n++;
            if (CSbar) csh++;
            if (bus.ready) got = 1;
        end
        bus.readMem = 1'b0;
        bus.chipSel = 1'($urandom_range(0, 1));
        bus.addressBus = 24'($urandom);
        chk("ready_seen", got, 1);
        chk("latency", n - 1, exp_lat);
        chk("data", bus.dataOut, exp_word(a));
        chk("cs_high_cycles", csh, exp_csh);
        chk("new_frames", frames - f0, exp_frame);
        if (exp_frame != 0) chk("cmd_addr", {f_cmd, f_addr}, {8'h03, a});
        $display("[TB] read %-6s addr=%06h data=%08h latency=%0d", kind, a, bus.dataOut, n - 1);
    endtask

    task automatic model_read(input logic [23:0] a, input int gap);
        int rise_at = 0, exp_rise;
        bit prev;
        prev = CSbar;
        for (int i = 1; i <= gap; i++) begin
            @(posedge clk); #1;
            if (CSbar && !prev && rise_at == 0) rise_at = i;
            prev = CSbar;
        end
        exp_rise = (open && gap >= H) ? H : 0;
        chk("timeout_cs_rise", rise_at, exp_rise);
        if (open && gap < H && a == 24'(last + 24'(N)))
            do_read(a, STRM_LAT, 0, 0, "stream");
        else if (open && gap < H)
            do_read(a, COLD_LAT + C, C, 1, "jump");
        else
            do_read(a, COLD_LAT, 0, 1, "cold");
        last = a;
        open = 1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gap, r;
        bit saw;
        logic [23:0] a;

        bus.chipSel = 1'b0; bus.readMem = 1'b0; bus.addressBus = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csbar", CSbar, 1);
        chk("rst_sck", SCK, 0);
        chk("rst_di", DI, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_data", bus.dataOut, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        model_read(24'h000020, 0);
        model_read(24'h000024, 2);
        model_read(24'h000100, 5);
        model_read(24'h000010, 0);
        model_read(24'hFFFFFC, 3);
        model_read(24'h000000, 0);
        model_read(24'h000004, H - 1);
        model_read(24'h000008, H + C);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      gap = $urandom_range(0, 8);
            else if (r < 8) gap = H - 1 - $urandom_range(0, 2);
            else            gap = H + C + $urandom_range(0, 4);
            if ($urandom_range(0, 2) != 0)      a = 24'(last + 24'(N));
            else if ($urandom_range(0, 7) == 0) a = 24'hFFFFFC;
            else                                a = 24'($urandom);
            model_read(a, gap);
        end

        // Asynchronous reset in the middle of the address phase
        bus.chipSel = 1'b1; bus.readMem = 1'b1; bus.addressBus = 24'h345678;
        saw = 0;
        repeat (30) begin @(posedge clk); #1; if (bus.ready) saw = 1; end
        #3 rst = 1'b0;
        #1;
        chk("arst_csbar", CSbar, 1);
        chk("arst_sck", SCK, 0);
        chk("arst_ready", bus.ready, 0);
        chk("arst_data", bus.dataOut, 0);
        chk("arst_no_ready", saw, 0);
        bus.chipSel = 1'b0; bus.readMem = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        open = 0;
        model_read(24'h345678, 1);

        // Request withdrawn during the data phase: no ready, data held
        bus.chipSel = 1'b1; bus.readMem = 1'b1; bus.addressBus = 24'h0ABCD0;
        saw = 0;
        repeat (100) begin @(posedge clk); #1; if (bus.ready) saw = 1; end
        bus.readMem = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.ready) saw = 1; end
        chk("drop_no_ready", saw, 0);
        chk("drop_data_kept", bus.dataOut, exp_word(24'h345678));
        open = 1;
        last = 24'h0ABCD0;
        model_read(24'h0ABCD4, 0);
        model_read(24'h0ABCD8, 4);

        chk("sck_high_while_cs_high", bad_sck, 0);
        chk("di_moved_while_sck_high", bad_di, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_burst_controller.md
# spi_flash_burst_controller

Parametrised successor to the single-byte SPI flash controller: serves instruction fetches from an external SPI NOR flash (READ 0x03, mode 0) for the AFTAB core. It returns 1, 2 or 4 bytes per access and divides SCK from `clk`. It streams sequential fetches without re-issuing command and address. Sits between the address decoder's instruction-memory chip select and the off-chip flash pins, replacing the byte-only controller.

## Interface
- `ADDR_W`, 24: flash address width; only 24 is legal (3 address bytes).
- `DATA_BYTES`, 1: bytes returned per access; legal values 1, 2, 4.
- `SCK_DIV`, 1: SCK half-period in `clk` cycles; ≥1.
- `CS_HIGH_MIN`, 2: minimum `CSbar` high time in `clk` cycles between frames.
- `HOLD_TIMEOUT`, 64: idle `clk` cycles in STREAM before the frame is closed; 0 disables streaming.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `chipSel` in 1: block selected by the address decoder.
- `readMem` in 1: read request; a request is `chipSel & readMem`.
- `addressBus` in ADDR_W: byte address of the first byte.
- `dataOut` out 8*DATA_BYTES: fetched data, little-endian; byte at `addressBus` is in [7:0].
- `ready` out 1: one-cycle pulse; `dataOut` is valid.
- `SCK` out 1: SPI clock, idle low.
- `CSbar` out 1: flash chip select, active low.
- `DI` out 1: serial data to flash, MSB first.
- `DO` in 1: serial data from flash.

## Operation
- States: IDLE, CSGAP, CMD, ADDR, DATA, RESP, STREAM.
- IDLE: a request moves to CMD; `CSbar` falls on the transition cycle, and the request address is latched.
- CMD: shift 8'h03, 8 SCK periods.
- ADDR: shift the latched address, 24 SCK periods.
- DATA: shift in 8*DATA_BYTES bits. Bits are MSB first within each byte, and bytes are packed from [7:0] upward. Then go to RESP.
- RESP: `dataOut` updates and `ready` pulses for one cycle. Next state is STREAM if HOLD_TIMEOUT>0, otherwise CSGAP.
- STREAM: `CSbar` stays low, `SCK` stays low, and the next expected address is last+DATA_BYTES mod 2^24.
  - Request at the expected address: go to DATA directly, with no command or address.
  - Request at any other address: go to CSGAP, then CMD.
  - No request for HOLD_TIMEOUT cycles: go to CSGAP, then IDLE.
- CSGAP: `CSbar`=1 for CS_HIGH_MIN cycles. It then goes to CMD if a request is pending, else to IDLE.
- Address wrap: 0xFFFFFF + 1 → 0x000000 counts as sequential, because the flash wraps identically.
- Request must be held until `ready`. If the request drops mid-frame, the current DATA phase still completes. In that case `ready` is suppressed and `dataOut` is unchanged. If the request is still absent in RESP, the block goes to STREAM.
- `addressBus` changes while busy are ignored until the next acceptance.
- Reset, asynchronous and mid-frame included, sets state IDLE. It also sets `CSbar`=1, `SCK`=0, `DI`=0, `ready`=0 and `dataOut`=0.

## Timing
- SCK period is 2*SCK_DIV `clk` cycles.
- `DI` changes only while `SCK` is low, on the falling edge or the frame start.
- `DO` is sampled on the `clk` edge that raises `SCK`.
- Cold access latency, from request sampled to `ready` high: 1 + 2*SCK_DIV*(32 + 8*DATA_BYTES) + 1 cycles.
  - Example: SCK_DIV=1, DATA_BYTES=4 gives 130 cycles.
- Streamed access latency: 2*SCK_DIV*8*DATA_BYTES + 1 cycles.
  - Example: SCK_DIV=1, DATA_BYTES=4 gives 65 cycles.
- A non-sequential access from STREAM adds CS_HIGH_MIN cycles to the cold latency.
- `ready` is registered; `dataOut` is registered and stable from `ready` until the next `ready`.
- SCK is never high while `CSbar` is high. The last SCK falling edge precedes `CSbar` rising by ≥1 `clk`.

## Structure
- Package `spi_flash_pkg`:
  - state enum;
  - `SPI_CMD_READ` = 8'h03;
  - `SPI_ADDR_BITS` = 24;
  - `DATA_BYTES` legality check function.
- Sub-module `spi_shift_engine`:
  - SCK divider and bit counter;
  - 32-bit TX shift register and 32-bit RX shift register;
  - `start`/`nbits`/`done` handshake.
- The FSM lives in the top module.

## Test plan
- Cold read, DATA_BYTES=1, SCK_DIV=1, flash[0x000010]=0xA5:
  - `DI` shows 0x03 then 0x000010;
  - `ready` at cycle 82;
  - `dataOut`=0xA5.
- DATA_BYTES=4, flash[0x20..0x23]=11 22 33 44, read 0x20 then 0x24:
  - first read gives `dataOut`=0x44332211 after 130 cycles;
  - second read needs no command/address, `ready` after 65 cycles, `CSbar` stays low.
- Streaming then non-sequential read of 0x100:
  - `CSbar` high for exactly CS_HIGH_MIN cycles;
  - full command frame follows;
  - correct data returned.
- Sequential read across 0xFFFFFC → 0x000000 (DATA_BYTES=4): streamed continuation returns flash[0..3].
- Idle in STREAM for HOLD_TIMEOUT=64 cycles:
  - `CSbar` rises at cycle 64;
  - next read of the expected address issues a full frame.
- `rst` low during ADDR:
  - `CSbar`=1 and `SCK`=0 immediately, asynchronously;
  - no `ready`;
  - after release, a fresh read completes correctly.
